// File: rtl/jt89_cmd.sv
// Command front-end for the SN76489-style PSG: turns tone/volume/noise commands into timed wr_n/dout byte writes.
// Optional JT89_CMD_SHADOW_EN: remembers the last tone data byte per channel and skips redundant data writes.
module jt89_cmd #(
  parameter int unsigned WR_HOLD = 4,
  parameter int unsigned WR_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [1:0] cmd_ch,
  input  logic [9:0] cmd_data,
  output logic       wr_n,
  output logic [7:0] dout,
  output logic       err
);

  localparam logic [7:0] HOLD_LAST = 8'(WR_HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(WR_GAP - 1);

  typedef enum logic [2:0] {IDLE, WR1, GAP1, WR2, GAP2} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_n_q, wr_n_d;
  logic [7:0] dout_q, dout_d;
  logic       ready_q, ready_d;
  logic       err_q, err_d;
  logic [5:0] hi_q, hi_d;
  logic       tone_q, tone_d;
  logic       skip_hi;
  logic       accept;
  logic       illegal;

`ifdef JT89_CMD_SHADOW_EN
  logic [1:0] ch_q, ch_d;
  logic [5:0] shadow_q [3];
  logic [5:0] shadow_d [3];
  logic [2:0] sh_vld_q, sh_vld_d;

  always_comb begin
    skip_hi = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (ch_q == 2'(i) && sh_vld_q[i] && shadow_q[i] == hi_q) skip_hi = 1'b1;
    end
  end
`else
  assign skip_hi = 1'b0;
`endif

  assign accept  = cmd_valid & ready_q;
  assign illegal = (cmd_type == 2'b11) || (cmd_type == 2'b00 && cmd_ch == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_n_d  = wr_n_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    hi_d    = hi_q;
    tone_d  = tone_q;
`ifdef JT89_CMD_SHADOW_EN
    ch_d     = ch_q;
    shadow_d = shadow_q;
    sh_vld_d = sh_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            state_d = WR1;
            wr_n_d  = 1'b0;
            cnt_d   = '0;
            tone_d  = (cmd_type == 2'b00);
            hi_d    = cmd_data[9:4];
`ifdef JT89_CMD_SHADOW_EN
            ch_d    = cmd_ch;
`endif
            case (cmd_type)
              2'b00:   dout_d = {1'b1, cmd_ch, 1'b0, cmd_data[3:0]};
              2'b01:   dout_d = {1'b1, cmd_ch, 1'b1, cmd_data[3:0]};
              default: dout_d = {1'b1, 3'b110, 1'b0, cmd_data[2:0]};
            endcase
          end
        end
      end
      WR1: begin
        if (clken) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            wr_n_d  = 1'b1;
            state_d = (tone_q && !skip_hi) ? GAP1 : GAP2;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      GAP1: begin
        if (clken) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            wr_n_d  = 1'b0;
            dout_d  = {2'b00, hi_q};
            state_d = WR2;
`ifdef JT89_CMD_SHADOW_EN
            for (int unsigned i = 0; i < 3; i++) begin
              if (ch_q == 2'(i)) begin
                shadow_d[i] = hi_q;
                sh_vld_d[i] = 1'b1;
              end
            end
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      WR2: begin
        if (clken) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            wr_n_d  = 1'b1;
            state_d = GAP2;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      GAP2: begin
        if (clken) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so that ready stays low during reset and rises on the first released edge.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_n_q   <= 1'b1;
      dout_q   <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      tone_q   <= 1'b0;
`ifdef JT89_CMD_SHADOW_EN
      ch_q     <= '0;
      shadow_q <= '{default: '0};
      sh_vld_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_n_q   <= wr_n_d;
      dout_q   <= dout_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      hi_q     <= hi_d;
      tone_q   <= tone_d;
`ifdef JT89_CMD_SHADOW_EN
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      sh_vld_q <= sh_vld_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign wr_n      = wr_n_q;
  assign dout      = dout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jt89_cmd.sv
// Directed bench for jt89_cmd: byte encodings, wr_n hold/gap timing, clken stalls, illegal commands, reset abort.
module tb_jt89_cmd;

  logic       clk;
  logic       rst_n;
  logic       clken;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [1:0] cmd_ch;
  logic [9:0] cmd_data;
  logic       wr_n;
  logic [7:0] dout;
  logic       err;

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0] bytes_c [4];
  int         low_c   [4];
  int         high_c  [4];
  int         nb;
  int         nerr;
  int         unstable;
  int         rdy_low;
  logic       rdy_first;
  logic       rdy_end;

  jt89_cmd #(.WR_HOLD(4), .WR_GAP(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clken     (clken),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_ch    (cmd_ch),
    .cmd_data  (cmd_data),
    .wr_n      (wr_n),
    .dout      (dout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command for exactly one rising edge; returns just after that edge.
  task automatic send(input logic [1:0] t, input logic [1:0] ch, input logic [9:0] d);
    @(negedge clk);
    cmd_type  = t;
    cmd_ch    = ch;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Samples n falling edges, splitting wr_n activity into bytes with low/high run lengths.
  task automatic capture(input int n, input bit toggle);
    logic prev;
    prev = 1'b1;
    nb = 0; nerr = 0; unstable = 0; rdy_low = 0;
    for (int i = 0; i < 4; i++) begin
      bytes_c[i] = '0;
      low_c[i]   = 0;
      high_c[i]  = 0;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) rdy_first = cmd_ready;
      if (err) nerr++;
      if (!cmd_ready) rdy_low++;
      if (!wr_n) begin
        if (prev && nb < 4) begin
          bytes_c[nb] = dout;
          nb++;
        end
        if (nb > 0) begin
          low_c[nb-1]++;
          if (dout != bytes_c[nb-1]) unstable++;
        end
      end else if (nb > 0 && !cmd_ready) begin
        high_c[nb-1]++;
        if (dout != bytes_c[nb-1]) unstable++;
      end
      prev = wr_n;
      if (toggle) clken = ~clken;
    end
    rdy_end = cmd_ready;
  endtask

  initial begin
    rst_n = 1'b0; clken = 1'b1; cmd_valid = 1'b0;
    cmd_type = '0; cmd_ch = '0; cmd_data = '0;

    repeat (2) @(negedge clk);
    check("rst_wr_n", wr_n, 1);
    check("rst_dout", dout, 8'h00);
    check("rst_ready", cmd_ready, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // tone ch0 3FF: latch 8F then data 3F
    send(2'b00, 2'd0, 10'h3FF);
    capture(14, 1'b0);
    check("tone_nbytes", nb, 2);
    check("tone_b0", bytes_c[0], 8'h8F);
    check("tone_low0", low_c[0], 4);
    check("tone_high0", high_c[0], 2);
    check("tone_b1", bytes_c[1], 8'h3F);
    check("tone_low1", low_c[1], 4);
    check("tone_high1", high_c[1], 2);
    check("tone_ready_end", rdy_end, 1);
    check("tone_stable", unstable, 0);
    check("tone_dout_hold", dout, 8'h3F);

    // volume ch1 = 4 with clken every other clk
    clken = 1'b1;
    send(2'b01, 2'd1, 10'h004);
    capture(16, 1'b1);
    clken = 1'b1;
    check("vol_nbytes", nb, 1);
    check("vol_b0", bytes_c[0], 8'hB4);
    check("vol_low0", low_c[0], 8);
    check("vol_high0", high_c[0], 4);
    check("vol_ready_end", rdy_end, 1);
    check("vol_stable", unstable, 0);

    // noise ctrl 111, cmd_ch ignored
    send(2'b10, 2'd2, 10'h007);
    capture(8, 1'b0);
    check("noise_nbytes", nb, 1);
    check("noise_b0", bytes_c[0], 8'hE7);
    check("noise_low0", low_c[0], 4);
    check("noise_high0", high_c[0], 2);

    // noise-channel volume is legal
    send(2'b01, 2'd3, 10'h00F);
    capture(8, 1'b0);
    check("vol3_nbytes", nb, 1);
    check("vol3_b0", bytes_c[0], 8'hFF);
    check("vol3_err", nerr, 0);

    // tone on ch3 is illegal
    send(2'b00, 2'd3, 10'h3FF);
    capture(4, 1'b0);
    check("ill_tone_err", nerr, 1);
    check("ill_tone_nbytes", nb, 0);
    check("ill_tone_ready", rdy_low, 0);

    // reserved type is illegal
    send(2'b11, 2'd0, 10'h000);
    capture(4, 1'b0);
    check("ill_type_err", nerr, 1);
    check("ill_type_nbytes", nb, 0);

    // reset during WR2 aborts the command
    send(2'b00, 2'd2, 10'h155);
    repeat (7) @(negedge clk);
    check("abort_wr2_wr_n", wr_n, 0);
    check("abort_wr2_dout", dout, 8'h15);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_wr_n", wr_n, 1);
    check("abort_ready", cmd_ready, 0);
    rst_n = 1'b1;
    capture(12, 1'b0);
    check("abort_ready_next", rdy_first, 1);
    check("abort_nbytes", nb, 0);

    // tone ch1 093 twice
    send(2'b00, 2'd1, 10'h093);
    capture(14, 1'b0);
    check("rep1_nbytes", nb, 2);
    check("rep1_b0", bytes_c[0], 8'hA3);
    check("rep1_b1", bytes_c[1], 8'h09);
    send(2'b00, 2'd1, 10'h093);
    capture(14, 1'b0);
    check("rep2_b0", bytes_c[0], 8'hA3);
    check("rep2_ready_end", rdy_end, 1);
`ifdef JT89_CMD_SHADOW_EN
    check("rep2_nbytes", nb, 1);
    check("rep2_low0", low_c[0], 4);
    check("rep2_high0", high_c[0], 2);
`else
    check("rep2_nbytes", nb, 2);
    check("rep2_b1", bytes_c[1], 8'h09);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/jt89_cmd.md
JT89_CMD -- requirements
Module: jt89_cmd

Interface
REQ-001 SHALL have parameter WR_HOLD, default 4: number of clken cycles wr_n is held low per byte (legal range 1-255).
REQ-002 SHALL have parameter WR_GAP, default 2: number of clken cycles wr_n is held high after each byte (legal range 1-255).
REQ-003 SHALL have port clk, input, 1 bit: single clock; one clock only, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port clken, input, 1 bit: timing enable; the WR_HOLD and WR_GAP counters advance only when clken=1.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a command is present.
REQ-007 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-008 SHALL have port cmd_type, input, 2 bits: 00 tone, 01 volume, 10 noise control, 11 reserved.
REQ-009 SHALL have port cmd_ch, input, 2 bits: channel; 3 means the noise channel.
REQ-010 SHALL have port cmd_data, input, 10 bits: tone period [9:0], volume [3:0], or noise control [2:0].
REQ-011 SHALL have port wr_n, output, 1 bit: active-low write strobe to the PSG.
REQ-012 SHALL have port dout, output, 8 bits: PSG write data byte.
REQ-013 SHALL have port err, output, 1 bit: one-clk pulse when an illegal command is accepted.

Function
REQ-014 SHALL accept a command on any clk edge with cmd_valid=1 and cmd_ready=1, independent of clken.
REQ-015 SHALL drive cmd_ready=1 only in state IDLE.
REQ-016 SHALL implement the FSM states IDLE, WR1, GAP1, WR2 and GAP2.
REQ-017 SHALL, for a tone command, form latch byte {1, ch, 0, data[3:0]} and data byte {2'b00, data[9:4]}.
REQ-018 SHALL step a tone command through IDLE→WR1→GAP1→WR2→GAP2→IDLE.
REQ-019 SHALL, for a volume command, form the single byte {1, ch, 1, data[3:0]}; ch=3 is legal and sets the noise volume.
REQ-020 SHALL, for a noise command, form the single byte {1, 3'b110, 0, data[2:0]}, ignoring cmd_ch.
REQ-021 SHALL step single-byte commands through IDLE→WR1→GAP2→IDLE.
REQ-022 SHALL, on acceptance, load dout and drive wr_n=0 on the same edge.
REQ-023 SHALL hold dout stable for the whole time wr_n=0 and while wr_n=1 until the next byte is loaded.
REQ-024 SHALL keep wr_n=0 in WR1/WR2 for exactly WR_HOLD clken cycles, then enter the gap state with wr_n=1.
REQ-025 SHALL keep wr_n=1 for WR_GAP clken cycles in each gap state.
REQ-026 SHALL, on the WR_GAP-th clken of GAP1, load the data byte and drive wr_n=0 on the same edge.
REQ-027 SHALL treat a tone command with ch=3, or cmd_type=11, as illegal: accept it, pulse err for one clk, issue no write, and stay in IDLE.
REQ-028 SHALL set cmd_ready=1 again on the edge that leaves GAP2; back-to-back commands SHALL be separated by at least WR_GAP high cycles.
REQ-029 SHALL freeze all counters while clken=0; wr_n and dout hold their values.

Reset
REQ-030 SHALL, on any edge with rst_n=0, set wr_n=1, dout=8'h00, cmd_ready=0, err=0, state=IDLE, and clear all counters.
REQ-031 SHALL drive cmd_ready=1 on the first edge with rst_n=1.
REQ-032 SHALL, when reset is asserted mid-operation, abort the command: wr_n=1 on that edge and the second byte is never issued.

Configuration
REQ-033 SHALL, with macro JT89_CMD_SHADOW_EN defined, keep a per-channel (ch 0-2) shadow of data[9:4] plus a valid bit, cleared by reset.
REQ-034 SHALL, with JT89_CMD_SHADOW_EN defined, skip the data byte (WR1→GAP2) for a tone command whose data[9:4] equals a valid shadow entry.
REQ-035 SHALL, with JT89_CMD_SHADOW_EN defined, update the shadow entry and set its valid bit on every issued data byte.
REQ-036 SHALL, without JT89_CMD_SHADOW_EN defined, contain no shadow logic and always send both tone bytes.

Verification
REQ-037 SHALL cover: defaults, clken=1, tone ch0 data 10'h3FF → dout 8'h8F with wr_n low 4 clk, high 2, then dout 8'h3F with wr_n low 4, high 2, then cmd_ready=1.
REQ-038 SHALL cover: volume ch1 data 4 with clken toggling every other clk → single byte 8'hB4, wr_n low for 8 clk.
REQ-039 SHALL cover: noise command data 3'b111, cmd_ch=2 → single byte 8'hE7.
REQ-040 SHALL cover: tone ch3 → err high for 1 clk, wr_n stays 1, cmd_ready stays 1.
REQ-041 SHALL cover: rst_n=0 for 1 clk during WR2 → wr_n=1 and cmd_ready=0 on that edge, cmd_ready=1 on the next edge, no further writes.
REQ-042 SHALL cover: with JT89_CMD_SHADOW_EN, tone ch1 data 10'h093 sent twice → first 8'hA3 then 8'h09; second time only 8'hA3.
